ddot_vec_loader: RTL and testbench
==================================

# ddot_vec_loader

Upstream feeder for `basic_ddot`. It accepts a serial stream of (x, y) single-precision element pairs over a valid/ready handshake and packs them into 8-lane chunks. It presents each chunk on the `x0..x7` / `y0..y7` buses and issues a one-cycle `ready` pulse to `basic_ddot`. Short final chunks are zero-padded so the dot product stays exact. An optional wait on `basic_ddot`'s `vld` throttles issue to one chunk in flight.

## Interface
- `WAIT_VLD`, default 1: 1 = after each issue, hold until `ddot_vld` before accepting more input; 0 = resume filling immediately.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_vld`  in  1  upstream element valid.
- `in_rdy`  out  1  loader can accept an element this cycle.
- `in_x`  in  32  x element, IEEE-754 single.
- `in_y`  in  32  y element, IEEE-754 single.
- `in_last`  in  1  this element is the final one of the vector.
- `ddot_vld`  in  1  result-valid from `basic_ddot`.
- `ready`  out  1  one-cycle issue strobe to `basic_ddot`.
- `x0`..`x7`  out  32 each  issued x lanes.
- `y0`..`y7`  out  32 each  issued y lanes.
- `chunk_last`  out  1  high with `ready` when the issued chunk contains the `in_last` element.
- `busy`  out  1  partial chunk held, issue in progress, or waiting on `ddot_vld`.

## Operation
- State machine with three states:
  - **FILL**: `in_rdy`=1. Each accept (`in_vld & in_rdy`) writes staging lane `idx` (x and y) and increments `idx` (3 bits). The first accepted beat of a chunk goes to lane 0.
  - If the accept has `idx==7` or `in_last`=1, go to ISSUE and latch `last_q = in_last`.
  - **ISSUE**: lasts exactly one cycle. `ready`=1, `chunk_last=last_q`, `in_rdy`=0. Staging is cleared to 0 and `idx` reset to 0. Next state is WAIT if `WAIT_VLD`=1, otherwise FILL.
  - **WAIT**: `in_rdy`=0. `ddot_vld`=1 moves to FILL on the next edge.
- Output lanes are separate registers, loaded from staging on the edge entering ISSUE. They hold until the next ISSUE load, so refilling staging never disturbs issued data.
- Zero padding: lanes not written in a short chunk are 32'h00000000 (+0.0), because staging is cleared after every issue and on reset.
- `ddot_vld` is ignored in FILL and ISSUE.
- `busy` = (state≠FILL) | (idx≠0).
- No arithmetic on data; elements pass bit-exact.

## Timing
- Reset (`rst`=1 at an edge) sets:
  - state to FILL, `idx`=0, staging=0;
  - `x0..x7`, `y0..y7` to 0;
  - `ready`, `chunk_last`, `busy` to 0.
- `in_rdy` is forced 0 during any cycle `rst` is high.
- `ready`/`chunk_last` are registered: high in the cycle immediately after the closing beat is accepted, low otherwise. The lane outputs change on that same edge.
- Throughput with `WAIT_VLD`=0: 9 cycles per full chunk (8 beats + 1 issue cycle) with continuous `in_vld`.
- `in_vld` gaps stall FILL with no side effect, and `idx` holds.
- `in_last` on beat 1 issues a chunk with lanes 1..7 = 0.
- `in_last` on beat 8 gives a normal full issue with `chunk_last`=1.
- `ddot_vld` in the same cycle as ISSUE is ignored.
- Reset mid-FILL or mid-WAIT discards the partial or outstanding chunk. No `ready` pulse is emitted.
- `ready` is never high on two consecutive cycles.

## Test plan
- **Full chunk**: 8 beats of x=32'h3f800000, y=32'h40000000, `in_last` on beat 8, `WAIT_VLD`=1.
  - One `ready` pulse one cycle after beat 8 with `chunk_last`=1.
  - All x lanes = 3f800000 and all y lanes = 40000000.
  - Downstream `basic_ddot` `z`=32'h41800000 (16.0).
- **Short chunk**: 3 beats (x = 1.0, 2.0, 3.0; y = 1.0) with `in_last` on beat 3.
  - `x0..x2` = 3f800000, 40000000, 40400000.
  - `x3..x7` and `y3..y7` = 0, `chunk_last`=1.
- **Throttle**: 16 beats streamed with `WAIT_VLD`=1 and `ddot_vld` held low.
  - The first `ready` pulse occurs, then `in_rdy`=0 and `busy`=1 indefinitely.
  - A `ddot_vld` pulse reopens `in_rdy` next cycle, and the second `ready` pulse follows 8 accepts later.
- **No-throttle**: `WAIT_VLD`=0 with 24 continuous beats.
  - `ready` pulses at cycles 9, 18 and 27 after the first accept.
  - Lane contents match the beat order.
- **Bubbles**: random `in_vld` gaps over 8 beats.
  - Lane ordering is unchanged and exactly one `ready` pulse occurs.
- **Reset mid-fill**: `rst` pulsed after 5 beats.
  - All outputs 0 and no `ready`.
  - The next 8 beats produce a clean chunk with beat 1 in lane 0.

Source files
------------

// File: rtl/ddot_vec_loader.sv
// rtl/ddot_vec_loader.sv - packs a serial (x, y) element stream into 8-lane chunks for basic_ddot
module ddot_vec_loader #(
  parameter bit WAIT_VLD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic        in_last,
  input  logic        ddot_vld,
  output logic        ready,
  output logic [31:0] x0,
  output logic [31:0] x1,
  output logic [31:0] x2,
  output logic [31:0] x3,
  output logic [31:0] x4,
  output logic [31:0] x5,
  output logic [31:0] x6,
  output logic [31:0] x7,
  output logic [31:0] y0,
  output logic [31:0] y1,
  output logic [31:0] y2,
  output logic [31:0] y3,
  output logic [31:0] y4,
  output logic [31:0] y5,
  output logic [31:0] y6,
  output logic [31:0] y7,
  output logic        chunk_last,
  output logic        busy
);

  typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [31:0] stage_x [8];
  logic [31:0] stage_y [8];
  logic [31:0] lane_x  [8];
  logic [31:0] lane_y  [8];
  logic [31:0] merge_x [8];
  logic [31:0] merge_y [8];
  logic        accept;
  logic        close;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    accept    = 1'b0;
    close     = 1'b0;
    case (state)
      S_FILL: begin
        in_rdy = ~rst;
        accept = in_vld & ~rst;
        close  = accept & ((idx == 3'd7) | in_last);
        if (close) state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = WAIT_VLD ? S_WAIT : S_FILL;
      S_WAIT:  if (ddot_vld) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  // The closing beat bypasses staging so the lanes capture it on the same edge.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      merge_x[i] = (accept && idx == 3'(i)) ? in_x : stage_x[i];
      merge_y[i] = (accept && idx == 3'(i)) ? in_y : stage_y[i];
    end
  end

  // Staging is emptied on the closing edge, so it is already zero while ISSUE is shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 3'd0;
      ready      <= 1'b0;
      chunk_last <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        stage_x[i] <= 32'h0;
        stage_y[i] <= 32'h0;
        lane_x[i]  <= 32'h0;
        lane_y[i]  <= 32'h0;
      end
    end else begin
      ready      <= close;
      chunk_last <= close & in_last;
      if (close) begin
        idx <= 3'd0;
        for (int i = 0; i < 8; i++) begin
          lane_x[i]  <= merge_x[i];
          lane_y[i]  <= merge_y[i];
          stage_x[i] <= 32'h0;
          stage_y[i] <= 32'h0;
        end
      end else if (accept) begin
        stage_x[idx] <= in_x;
        stage_y[idx] <= in_y;
        idx          <= idx + 3'd1;
      end
    end
  end

  assign busy = (state != S_FILL) || (idx != 3'd0);

  assign x0 = lane_x[0];
  assign x1 = lane_x[1];
  assign x2 = lane_x[2];
  assign x3 = lane_x[3];
  assign x4 = lane_x[4];
  assign x5 = lane_x[5];
  assign x6 = lane_x[6];
  assign x7 = lane_x[7];
  assign y0 = lane_y[0];
  assign y1 = lane_y[1];
  assign y2 = lane_y[2];
  assign y3 = lane_y[3];
  assign y4 = lane_y[4];
  assign y5 = lane_y[5];
  assign y6 = lane_y[6];
  assign y7 = lane_y[7];

endmodule

// File: tb/tb_ddot_vec_loader.sv
// tb/tb_ddot_vec_loader.sv - directed and randomized bench for ddot_vec_loader (both WAIT_VLD settings)
module tb_ddot_vec_loader;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_vld = 1'b0;
  logic [31:0] in_x = 32'h0;
  logic [31:0] in_y = 32'h0;
  logic        in_last = 1'b0;
  logic        ddot_vld = 1'b0;

  logic        a_rdy, a_ready, a_cl, a_busy;
  logic        b_rdy, b_ready, b_cl, b_busy;
  logic [31:0] ax [8];
  logic [31:0] ay [8];
  logic [31:0] bx [8];
  logic [31:0] by [8];

  always #5 clk = ~clk;

  ddot_vec_loader #(.WAIT_VLD(1'b1)) dut_wait (
    .clk(clk), .rst(rst), .in_vld(in_vld & ~sel), .in_rdy(a_rdy),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .ddot_vld(ddot_vld), .ready(a_ready),
    .x0(ax[0]), .x1(ax[1]), .x2(ax[2]), .x3(ax[3]), .x4(ax[4]), .x5(ax[5]), .x6(ax[6]), .x7(ax[7]),
    .y0(ay[0]), .y1(ay[1]), .y2(ay[2]), .y3(ay[3]), .y4(ay[4]), .y5(ay[5]), .y6(ay[6]), .y7(ay[7]),
    .chunk_last(a_cl), .busy(a_busy)
  );

  ddot_vec_loader #(.WAIT_VLD(1'b0)) dut_free (
    .clk(clk), .rst(rst), .in_vld(in_vld & sel), .in_rdy(b_rdy),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .ddot_vld(ddot_vld), .ready(b_ready),
    .x0(bx[0]), .x1(bx[1]), .x2(bx[2]), .x3(bx[3]), .x4(bx[4]), .x5(bx[5]), .x6(bx[6]), .x7(bx[7]),
    .y0(by[0]), .y1(by[1]), .y2(by[2]), .y3(by[3]), .y4(by[4]), .y5(by[5]), .y6(by[6]), .y7(by[7]),
    .chunk_last(b_cl), .busy(b_busy)
  );

  logic         o_rdy, o_ready, o_cl, o_busy;
  logic [255:0] o_xv, o_yv;
  assign o_rdy   = sel ? b_rdy   : a_rdy;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_cl    = sel ? b_cl    : a_cl;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_xv = sel ? {bx[7], bx[6], bx[5], bx[4], bx[3], bx[2], bx[1], bx[0]}
                    : {ax[7], ax[6], ax[5], ax[4], ax[3], ax[2], ax[1], ax[0]};
  assign o_yv = sel ? {by[7], by[6], by[5], by[4], by[3], by[2], by[1], by[0]}
                    : {ay[7], ay[6], ay[5], ay[4], ay[3], ay[2], ay[1], ay[0]};

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int npulse = 0;
  int d_edge = 0;
  int first_beat_x;
  logic bubbles = 1'b0;
  logic rand_ddot = 1'b0;

  // Reference model: pending beats of the open chunk plus "issuing"/"waiting" flags.
  beat_t        stim [$];
  beat_t        cur [$];
  int           acc_edges [$];
  int           ready_edges [$];
  logic         m_issue = 1'b0;
  logic         m_wait = 1'b0;
  logic         m_last = 1'b0;
  logic [255:0] m_x = '0;
  logic [255:0] m_y = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    beat_t b;
    logic  acc, exp_rdy;
    if (stim.size() > 0 && (!bubbles || $urandom_range(0, 2) != 0)) begin
      in_vld = 1'b1; in_x = stim[0].x; in_y = stim[0].y; in_last = stim[0].last;
    end else begin
      in_vld = 1'b0; in_x = $urandom; in_y = $urandom; in_last = 1'($urandom_range(0, 1));
    end
    if (rand_ddot) ddot_vld = ($urandom_range(0, 3) == 0);
    #1;
    exp_rdy = !rst && !m_issue && !m_wait;
    chk("in_rdy", o_rdy, exp_rdy);
    acc = in_vld && exp_rdy;
    @(posedge clk);
    #1;
    edge_n++;
    if (rst) begin
      cur.delete(); m_issue = 1'b0; m_wait = 1'b0; m_x = '0; m_y = '0; m_last = 1'b0;
    end else if (m_issue) begin
      m_issue = 1'b0;
      m_wait  = !sel;
    end else if (m_wait) begin
      if (ddot_vld) m_wait = 1'b0;
    end else if (acc) begin
      b = stim.pop_front();
      cur.push_back(b);
      acc_edges.push_back(edge_n);
      if (cur.size() == 8 || b.last) begin
        m_x = '0; m_y = '0;
        foreach (cur[i]) begin
          m_x[32*i +: 32] = cur[i].x;
          m_y[32*i +: 32] = cur[i].y;
        end
        m_last  = b.last;
        m_issue = 1'b1;
        cur.delete();
      end
    end
    if (o_ready) begin
      ready_edges.push_back(edge_n);
      npulse++;
    end
    chk("ready", o_ready, m_issue);
    chk("chunk_last", o_cl, m_issue && m_last);
    chk("busy", o_busy, m_issue || m_wait || cur.size() != 0);
    chk("x_lanes", o_xv, m_x);
    chk("y_lanes", o_yv, m_y);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic last);
    beat_t b;
    b.x = x; b.y = y; b.last = last;
    stim.push_back(b);
  endtask

  task automatic do_reset();
    stim.delete();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  task automatic ddot_pulse();
    ddot_vld = 1'b1;
    tick();
    ddot_vld = 1'b0;
  endtask

  task automatic rand_phase(input int n);
    bubbles = 1'b1; rand_ddot = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (stim.size() < 3) push($urandom, $urandom, $urandom_range(0, 5) == 0);
      tick();
    end
    bubbles = 1'b0; rand_ddot = 1'b0; ddot_vld = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_ready", o_ready, 1'b0);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_x", o_xv, 256'h0);
    chk("reset_y", o_yv, 256'h0);

    // full chunk
    npulse = 0;
    for (int i = 0; i < 8; i++) push(32'h3f800000, 32'h40000000, i == 7);
    run(12);
    chk("full_pulses", npulse, 1);
    chk("full_x", o_xv, {8{32'h3f800000}});
    chk("full_y", o_yv, {8{32'h40000000}});
    ddot_pulse();

    // short chunk
    push(32'h3f800000, 32'h3f800000, 1'b0);
    push(32'h40000000, 32'h3f800000, 1'b0);
    push(32'h40400000, 32'h3f800000, 1'b1);
    run(6);
    chk("short_x", o_xv, {160'h0, 32'h40400000, 32'h40000000, 32'h3f800000});
    chk("short_y", o_yv, {160'h0, {3{32'h3f800000}}});
    ddot_pulse();

    // throttle
    npulse = 0;
    for (int i = 0; i < 16; i++) push($urandom, $urandom, 1'b0);
    run(40);
    chk("thr_pulses", npulse, 1);
    chk("thr_in_rdy", o_rdy, 1'b0);
    chk("thr_busy", o_busy, 1'b1);
    chk("thr_left", stim.size(), 8);
    ddot_vld = 1'b1;
    tick();
    d_edge = edge_n;
    ddot_vld = 1'b0;
    ready_edges.delete();
    run(20);
    chk("thr_second", ready_edges.size(), 1);
    chk("thr_latency", ready_edges.size() > 0 ? ready_edges[0] - d_edge : -1, 8);
    ddot_pulse();

    // reset mid-fill
    for (int i = 0; i < 5; i++) push($urandom, $urandom, 1'b0);
    run(5);
    npulse = 0;
    do_reset();
    run(2);
    chk("rst_pulses", npulse, 0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_x", o_xv, 256'h0);
    first_beat_x = 32'h1234abcd;
    push(32'h1234abcd, $urandom, 1'b0);
    for (int i = 1; i < 8; i++) push($urandom, $urandom, 1'b0);
    run(12);
    chk("rst_lane0", o_xv[31:0], 32'(first_beat_x));
    chk("rst_clean_pulses", npulse, 1);
    ddot_pulse();

    // bubbles
    npulse = 0;
    for (int i = 0; i < 8; i++) push($urandom, $urandom, 1'b0);
    bubbles = 1'b1;
    run(60);
    bubbles = 1'b0;
    chk("bub_pulses", npulse, 1);
    ddot_pulse();

    rand_phase(300);

    // no-throttle instance
    sel = 1'b1;
    do_reset();
    acc_edges.delete();
    ready_edges.delete();
    for (int i = 0; i < 24; i++) push($urandom, $urandom, i == 23);
    run(32);
    chk("nt_pulses", ready_edges.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("nt_timing", (ready_edges.size() > i && acc_edges.size() > 0) ? ready_edges[i] - acc_edges[0] : -1, 7 + 9 * i);
    rand_phase(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
